// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clk_div_bank divider bank.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RUN_PEND = 2'd2
  } chan_state_e;

  localparam int unsigned DEFAULT_DIV = 100000;

  // Channel-select width; a single-channel bank still gets a 1-bit select.
  function automatic int unsigned chan_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, run FSM, live/pending divide and tick/toggle outputs.
// Optional start phase under `define CLK_DIV_BANK_PHASE_EN.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = 27,
  parameter int unsigned RST_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
`ifdef CLK_DIV_BANK_PHASE_EN
  input  logic [DIV_W-1:0] cfg_phase,
`endif
  output logic             pending_c,
  output logic             tick,
  output logic             div_out
);

  chan_state_e      state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] load_cnt_c;
  logic [DIV_W-1:0] commit_div_c;
  logic             term_c;

`ifdef CLK_DIV_BANK_PHASE_EN
  logic [DIV_W-1:0] phase_q;
  assign load_cnt_c = cfg_we ? cfg_phase : phase_q;
`else
  assign load_cnt_c = '0;
`endif

  assign term_c    = (cnt == (div_q - DIV_W'(1)));
  assign pending_c = (state == RUN_PEND);

  // Divide value that becomes live when leaving RUN/RUN_PEND or on restart; a same-cycle write wins.
  assign commit_div_c = cfg_we ? cfg_div : (pending_c ? pend_div : div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_q    <= DIV_W'(RST_DIV);
      pend_div <= '0;
      tick     <= 1'b0;
      div_out  <= 1'b0;
`ifdef CLK_DIV_BANK_PHASE_EN
      phase_q  <= '0;
`endif
    end else begin
`ifdef CLK_DIV_BANK_PHASE_EN
      if (cfg_we) phase_q <= cfg_phase;
`endif
      case (state)
        IDLE: begin
          cnt     <= '0;
          tick    <= 1'b0;
          div_out <= 1'b0;
          if (cfg_we) div_q <= cfg_div;
          if (en) begin
            state <= RUN;
            cnt   <= load_cnt_c;
          end
        end
        default: begin
          if (!en) begin
            state   <= IDLE;
            cnt     <= '0;
            tick    <= 1'b0;
            div_out <= 1'b0;
            div_q   <= commit_div_c;
          end else if (restart) begin
            state   <= RUN;
            cnt     <= load_cnt_c;
            tick    <= 1'b0;
            div_out <= 1'b0;
            div_q   <= commit_div_c;
          end else if (term_c) begin
            cnt     <= '0;
            tick    <= 1'b1;
            div_out <= ~div_out;
            if (pending_c) begin
              div_q <= pend_div;
              state <= RUN;
            end else if (cfg_we) begin
              pend_div <= cfg_div;
              state    <= RUN_PEND;
            end
          end else begin
            cnt  <= cnt + DIV_W'(1);
            tick <= 1'b0;
            if (cfg_we) begin
              pend_div <= cfg_div;
              state    <= RUN_PEND;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers sharing one cfg port.
// Optional start phase per channel under `define CLK_DIV_BANK_PHASE_EN.
module clk_div_bank #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 27,
  parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_CH-1:0]                            en,
  input  logic                                         restart,
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [clk_div_pkg::chan_idx_w(NUM_CH)-1:0]   cfg_chan,
  input  logic [DIV_W-1:0]                             cfg_div,
`ifdef CLK_DIV_BANK_PHASE_EN
  input  logic [DIV_W-1:0]                             cfg_phase,
`endif
  output logic                                         cfg_err,
  output logic [NUM_CH-1:0]                            div_out,
  output logic [NUM_CH-1:0]                            tick
);
  import clk_div_pkg::*;

  localparam int unsigned CH_W   = chan_idx_w(NUM_CH);
  localparam int unsigned PAD_CH = 1 << CH_W;

  if (DEFAULT_DIV == 0) begin : g_bad_default_div
    $fatal(1, "clk_div_bank: DEFAULT_DIV must be >= 1");
  end
  if (NUM_CH == 0 || NUM_CH > 16) begin : g_bad_num_ch
    $fatal(1, "clk_div_bank: NUM_CH must be in 1..16");
  end

  logic [NUM_CH-1:0] pend_c;
  logic [NUM_CH-1:0] cfg_we_c;
  logic [PAD_CH-1:0] pend_pad_c;
  logic              chan_ok_c;
  logic              bad_c;
  logic              accept_c;

  // Pad the pending vector so any encodable channel index selects a defined bit.
  assign pend_pad_c = PAD_CH'(pend_c);
  assign chan_ok_c  = ({1'b0, cfg_chan} < (CH_W+1)'(NUM_CH));
  assign cfg_ready  = ~pend_pad_c[cfg_chan];

`ifdef CLK_DIV_BANK_PHASE_EN
  assign bad_c = (cfg_div == '0) || !chan_ok_c || (cfg_phase >= cfg_div);
`else
  assign bad_c = (cfg_div == '0) || !chan_ok_c;
`endif

  assign accept_c = cfg_valid && cfg_ready && !bad_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_valid && bad_c;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign cfg_we_c[i] = accept_c && (cfg_chan == CH_W'(i));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .RST_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en[i]),
      .restart   (restart),
      .cfg_we    (cfg_we_c[i]),
      .cfg_div   (cfg_div),
`ifdef CLK_DIV_BANK_PHASE_EN
      .cfg_phase (cfg_phase),
`endif
      .pending_c (pend_c[i]),
      .tick      (tick[i]),
      .div_out   (div_out[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: tick scoreboard plus cfg vector table.
module tb_clk_div_bank;

  localparam int unsigned NUM_CH  = 3;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned DEF_DIV = 4;
  localparam int unsigned CH_W    = 2;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic [NUM_CH-1:0] en        = '0;
  logic              restart   = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_chan  = '0;
  logic [DIV_W-1:0]  cfg_div   = '0;
`ifdef CLK_DIV_BANK_PHASE_EN
  logic [DIV_W-1:0]  cfg_phase = '0;
`endif
  logic              cfg_ready;
  logic              cfg_err;
  logic [NUM_CH-1:0] div_out;
  logic [NUM_CH-1:0] tick;

  clk_div_bank #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEF_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .restart   (restart),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
`ifdef CLK_DIV_BANK_PHASE_EN
    .cfg_phase (cfg_phase),
`endif
    .cfg_err   (cfg_err),
    .div_out   (div_out),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ch;
    int cyc;
    int dout;
  } tick_ev_t;

  typedef struct {
    logic [CH_W-1:0]  chan;
    logic [DIV_W-1:0] div;
    logic             exp_err;
    logic             exp_ready;
  } cfg_vec_t;

  tick_ev_t          exp_q[$];
  logic [NUM_CH-1:0] mon_mask = '0;
  cfg_vec_t          vecs[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_tick(input int ch, input int c, input int dout);
    tick_ev_t e;
    e.ch = ch;
    e.cyc = c;
    e.dout = dout;
    exp_q.push_back(e);
  endtask

  // Advance one clock, sample 1ns later, and match observed ticks against the queue.
  task automatic step();
    tick_ev_t e;
    @(posedge clk);
    #1;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (mon_mask[c] && tick[c]) begin
        if (exp_q.size() == 0) begin
          check("tick_unexpected_ch", c, -1);
        end else begin
          e = exp_q.pop_front();
          check("tick_ch", c, e.ch);
          check("tick_cycle", cyc, e.cyc);
          check("tick_div_out", int'(div_out[c]), e.dout);
        end
      end
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic sb_done(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
    mon_mask = '0;
  endtask

  task automatic cfg_write(input int chan, input int div);
    cfg_chan  = CH_W'(chan);
    cfg_div   = DIV_W'(div);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int r;
    int p;

    vecs[0] = '{chan: 2'd0, div: 8'd0, exp_err: 1'b1, exp_ready: 1'b1};
    vecs[1] = '{chan: 2'd3, div: 8'd5, exp_err: 1'b1, exp_ready: 1'b1};
    vecs[2] = '{chan: 2'd1, div: 8'd0, exp_err: 1'b1, exp_ready: 1'b1};
    vecs[3] = '{chan: 2'd2, div: 8'd7, exp_err: 1'b0, exp_ready: 1'b1};

    // Reset state
    #7;
    check("rst_tick", int'(tick), 0);
    check("rst_div_out", int'(div_out), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    #5 rst_n = 1'b1;
    step();

    // Default divide on ch0, en falling on a terminal count
    k = cyc;
    en = 3'b001;
    mon_mask = 3'b111;
    expect_tick(0, k + 5, 1);
    expect_tick(0, k + 9, 0);
    run_to(k + 12);
    en = 3'b000;
    step();
    check("en_fall_tick", int'(tick[0]), 0);
    check("en_fall_div_out", int'(div_out[0]), 0);
    check("idle_other_div_out", int'(div_out[2:1]), 0);
    sb_done("s1_sb_empty");

    // Update while running: period in progress finishes on old divide
    k = cyc;
    en = 3'b001;
    mon_mask = 3'b001;
    expect_tick(0, k + 5, 1);
    expect_tick(0, k + 7, 0);
    expect_tick(0, k + 9, 1);
    run_to(k + 2);
    cfg_chan = 2'd0;
    cfg_div = 8'd2;
    cfg_valid = 1'b1;
    #1;
    check("upd_ready_before", int'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0;
    check("upd_ready_pend_a", int'(cfg_ready), 0);
    step();
    check("upd_ready_pend_b", int'(cfg_ready), 0);
    step();
    check("upd_ready_after_tc", int'(cfg_ready), 1);
    run_to(k + 9);
    sb_done("s2_sb_empty");
    en = 3'b000;
    step();
    cfg_write(0, DEF_DIV);

    // Rejected and accepted cfg requests
    for (int i = 0; i < 4; i++) begin
      cfg_chan = vecs[i].chan;
      cfg_div = vecs[i].div;
      cfg_valid = 1'b1;
      #1;
      check($sformatf("vec%0d_ready", i), int'(cfg_ready), int'(vecs[i].exp_ready));
      step();
      cfg_valid = 1'b0;
      check($sformatf("vec%0d_err", i), int'(cfg_err), int'(vecs[i].exp_err));
      step();
      check($sformatf("vec%0d_err_clear", i), int'(cfg_err), 0);
    end
    k = cyc;
    en = 3'b101;
    mon_mask = 3'b101;
    expect_tick(0, k + 5, 1);
    expect_tick(2, k + 8, 1);
    run_to(k + 8);
    sb_done("s3_sb_empty");
    en = 3'b000;
    step();

    // Divide by one: tick held high, div_out at clk/2
    cfg_write(1, 1);
    k = cyc;
    en = 3'b010;
    mon_mask = 3'b010;
    for (int j = 0; j < 4; j++) expect_tick(1, k + 2 + j, (j % 2 == 0) ? 1 : 0);
    run_to(k + 5);
    sb_done("s4_sb_empty");
    en = 3'b000;
    step();
    check("div1_off_tick", int'(tick[1]), 0);
    check("div1_off_div_out", int'(div_out[1]), 0);

    // Restart mid-period on two channels
    cfg_write(0, 3);
    cfg_write(2, 5);
    k = cyc;
    en = 3'b101;
    mon_mask = 3'b101;
    expect_tick(0, k + 4, 1);
    expect_tick(2, k + 6, 1);
    expect_tick(0, k + 7, 0);
    run_to(k + 8);
    restart = 1'b1;
    step();
    restart = 1'b0;
    r = cyc;
    check("restart_div_out", int'(div_out), 0);
    check("restart_tick", int'(tick), 0);
    expect_tick(0, r + 3, 1);
    expect_tick(2, r + 5, 1);
    expect_tick(0, r + 6, 0);
    run_to(r + 6);
    sb_done("s5_sb_empty");

    // Pending update committed by restart
    mon_mask = 3'b001;
    cfg_chan = 2'd0;
    cfg_div = 8'd6;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("pend_ready_low", int'(cfg_ready), 0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("pend_ready_restart", int'(cfg_ready), 1);
    p = cyc;
    expect_tick(0, p + 6, 1);
    expect_tick(0, p + 12, 0);
    run_to(p + 12);
    sb_done("s6_sb_empty");
    run_to(p + 19);
    check("pre_reset_div_out", int'(div_out), 5);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    en = 3'b000;
    #1;
    check("async_rst_div_out", int'(div_out), 0);
    check("async_rst_tick", int'(tick), 0);
    #2 rst_n = 1'b1;
    step();
    k = cyc;
    en = 3'b001;
    mon_mask = 3'b001;
    expect_tick(0, k + 5, 1);
    run_to(k + 5);
    sb_done("s7_sb_empty");
    en = 3'b000;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
